ctrl_input_conditioner: RTL and testbench
=========================================

Name: ctrl_input_conditioner

Overview:
- Front-end conditioner between the board's raw KEY/SW pins and the audioplay system's control PIOs.
- Synchronises and debounces the previous/next/reset push-buttons and the pause/filter1/filter2 slide switches.
- Buttons produce single-cycle press pulses, with auto-repeat on long hold for previous/next. Switches produce clean levels.
- Output pulses target edge-capture PIOs; output levels target level-read PIOs.

Parameters:
- DEBOUNCE_CYCLES, 1000000: cycles a synced input must differ from its debounced state before the state flips (20 ms @ 50 MHz).
- HOLD_CYCLES, 25000000: cycles from the first previous/next pulse to the first repeat pulse (500 ms).
- REPEAT_CYCLES, 7500000: cycles between subsequent repeat pulses (150 ms).

Ports:
- clk_clk  in  1  system clock, 50 MHz
- reset_reset_n  in  1  asynchronous active-low reset
- anterior_key_n  in  1  raw previous button, active-low
- siguiente_key_n  in  1  raw next button, active-low
- rst_key_n  in  1  raw playback-reset button, active-low
- pausa_sw  in  1  raw pause switch, active-high
- filtro1_sw  in  1  raw filter-1 switch
- filtro2_sw  in  1  raw filter-2 switch
- anterior_pulse  out  1  one-cycle previous request
- siguiente_pulse  out  1  one-cycle next request
- rst_pulse  out  1  one-cycle playback-reset request
- pausa_lvl  out  1  debounced pause level
- filtro1_lvl  out  1  debounced filter-1 level
- filtro2_lvl  out  1  debounced filter-2 level

Behaviour:
- Clock and reset: one clock (clk_clk). Reset (reset_reset_n) is asynchronous assert, active-low. All flops reset. All outputs reset to 0.
- Per-channel pipeline:
  - Inputs are inverted to active-high first for the _n ports.
  - 2-FF synchroniser; sync flops reset to 0, i.e. released/off.
  - Debounced state d (reset 0) and counter cnt (reset 0).
  - If sync == d: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: d <= sync, cnt <= 0.
  - Else: cnt++.
  - Glitches shorter than DEBOUNCE_CYCLES are fully rejected; any mismatch gap restarts the count.
- Latency: a clean input transition before edge 0 gives d updated at edge DEBOUNCE_CYCLES+1. Level outputs are registered d, valid at edge DEBOUNCE_CYCLES+2. Pulses are registered and asserted for exactly the cycle after edge DEBOUNCE_CYCLES+2.
- Switch on at reset release: level rises after the normal latency. There is no output at reset time.
- rst channel: pulse on the d rising edge only. No repeat.
- Previous/next FSM, per channel:
  - IDLE → HELD on d rise: emit pulse, hcnt <= 0.
  - HELD: d fall → IDLE. Otherwise if hcnt == HOLD_CYCLES-1: emit pulse, hcnt <= 0, → REPEAT. Otherwise hcnt++.
  - REPEAT: d fall → IDLE. Otherwise if hcnt == REPEAT_CYCLES-1: emit pulse, hcnt <= 0. Otherwise hcnt++.
  - Release is always checked before the counter terminal; release on the terminal cycle gives no pulse.
- Mutual exclusion:
  - A previous/next pulse is suppressed in any cycle where the other channel's d is 1.
  - FSMs and counters keep running while suppressed.
  - If both d rise in the same cycle, neither pulses.
- Counter widths are $clog2 of the respective parameter. A counter never wraps past its terminal value.
- Reset mid-hold: FSM → IDLE, d → 0. A still-held button re-pulses only after a full debounce following reset release.

Optional Feature:
- Macro: CTRL_AUTOREPEAT_EN.
- Defined: HELD/REPEAT behaviour exactly as above.
- Undefined:
  - HELD only waits for release.
  - The REPEAT state and HOLD/REPEAT counters are not built.
  - Exactly one pulse per press.
  - HOLD_CYCLES and REPEAT_CYCLES are ignored.

Decomposition:
- Package ctrl_input_pkg:
  - nav_state_t enum: IDLE, HELD, REPEAT.
  - Default cycle constants for 50 MHz.
  - Helper localparam-style width function.
- Sub-module ctrl_debounce: synchroniser plus debounce counter, parameter DEBOUNCE_CYCLES. Instantiated six times.
- Previous/next FSM, edge detect and exclusion logic live in the top.

Test Plan (DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8):
- pausa_sw 0→1 clean at edge 0 → pausa_lvl=1 from edge 6. A 3-cycle 1-glitch on filtro1_sw → filtro1_lvl stays 0.
- siguiente_key_n low 10 cycles, then high → exactly one siguiente_pulse, 1 cycle wide, at edge 6; anterior_pulse stays 0.
- siguiente_key_n held low 60 cycles, with CTRL_AUTOREPEAT_EN → pulses at edges 6, 26, 34, 42, 50, 58, then none after release. Without CTRL_AUTOREPEAT_EN → single pulse at edge 6.
- Both keys pressed in the same cycle, held 40 cycles → no anterior_pulse or siguiente_pulse at all.
- Press anterior held; assert reset_reset_n=0 at edge 15 for 2 cycles → all outputs 0 immediately. One new anterior_pulse after debounce following release.
- rst_key_n with 1-cycle bounces for 6 cycles, then held low 30 cycles → exactly one rst_pulse.

Source files
------------

// File: rtl/ctrl_input_pkg.sv
// Shared types and constants for the KEY/SW input conditioner.
// Default cycle counts assume a 50 MHz system clock.
package ctrl_input_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        REPEAT
    } nav_state_t;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;  // 20 ms
    localparam int unsigned DEF_HOLD_CYCLES     = 25000000; // 500 ms
    localparam int unsigned DEF_REPEAT_CYCLES   = 7500000;  // 150 ms

    // Channel order of the debounced bus inside the top.
    localparam int unsigned CH_ANT   = 0;
    localparam int unsigned CH_SIG   = 1;
    localparam int unsigned CH_RST   = 2;
    localparam int unsigned CH_PAUSA = 3;
    localparam int unsigned CH_F1    = 4;
    localparam int unsigned CH_F2    = 5;
    localparam int unsigned NUM_CH   = 6;

    // Width of a counter spanning 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ctrl_debounce.sv
// One input channel: 2-FF synchroniser followed by a debounce counter.
// The debounced state flips only after DEBOUNCE_CYCLES consecutive mismatches.
module ctrl_debounce
    import ctrl_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_d
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_d;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_d     <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            // Any agreement restarts the count, so short glitches never accumulate.
            if (r_sync2 == r_d) begin
                r_cnt <= '0;
            end else if (r_cnt == TERM) begin
                r_d   <= r_sync2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_d = r_d;

endmodule

// File: rtl/ctrl_input_conditioner.sv
// Debounces KEY/SW pins into press pulses and clean levels for the control PIOs.
// Define CTRL_AUTOREPEAT_EN to add hold-to-repeat on the previous/next buttons.
module ctrl_input_conditioner
    import ctrl_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
    input  logic clk_clk,
    input  logic reset_reset_n,
    input  logic anterior_key_n,
    input  logic siguiente_key_n,
    input  logic rst_key_n,
    input  logic pausa_sw,
    input  logic filtro1_sw,
    input  logic filtro2_sw,
    output logic anterior_pulse,
    output logic siguiente_pulse,
    output logic rst_pulse,
    output logic pausa_lvl,
    output logic filtro1_lvl,
    output logic filtro2_lvl
);

    logic [NUM_CH-1:0] w_raw;
    logic [NUM_CH-1:0] w_d;
    logic [1:0]        w_nav_d;
    logic [1:0]        w_nav_other;

    nav_state_t        r_state [2];
    logic [1:0]        r_nav_pulse;
    logic              r_rst_d_q;
    logic              r_rst_pulse;
    logic [2:0]        r_lvl;

    assign w_raw = {filtro2_sw, filtro1_sw, pausa_sw,
                    ~rst_key_n, ~siguiente_key_n, ~anterior_key_n};

    for (genvar g = 0; g < NUM_CH; g++) begin : g_deb
        ctrl_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .i_clk  (clk_clk),
            .i_rst_n(reset_reset_n),
            .i_raw  (w_raw[g]),
            .o_d    (w_d[g])
        );
    end

    assign w_nav_d     = {w_d[CH_SIG], w_d[CH_ANT]};
    // Each nav channel sees the other's debounced state for mutual exclusion.
    assign w_nav_other = {w_d[CH_ANT], w_d[CH_SIG]};

`ifdef CTRL_AUTOREPEAT_EN
    localparam int unsigned HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned HW   = cnt_width(HMAX);
    localparam logic [HW-1:0] HOLD_TERM   = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] REPEAT_TERM = HW'(REPEAT_CYCLES - 1);

    logic [HW-1:0] r_hcnt [2];
`else
    // Hold/repeat timing has no hardware in this build.
    logic [63:0] w_unused_cfg;
    assign w_unused_cfg = {HOLD_CYCLES, REPEAT_CYCLES};
`endif

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            for (int i = 0; i < 2; i++) begin
                r_state[i]     <= IDLE;
                r_nav_pulse[i] <= 1'b0;
`ifdef CTRL_AUTOREPEAT_EN
                r_hcnt[i]      <= '0;
`endif
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                r_nav_pulse[i] <= 1'b0;
                // Release is tested first so a release on the terminal cycle emits nothing.
                case (r_state[i])
                    IDLE: begin
                        if (w_nav_d[i]) begin
                            r_state[i]     <= HELD;
                            r_nav_pulse[i] <= ~w_nav_other[i];
`ifdef CTRL_AUTOREPEAT_EN
                            r_hcnt[i]      <= '0;
`endif
                        end
                    end
                    HELD: begin
                        if (!w_nav_d[i]) begin
                            r_state[i] <= IDLE;
                        end
`ifdef CTRL_AUTOREPEAT_EN
                        else if (r_hcnt[i] == HOLD_TERM) begin
                            r_state[i]     <= REPEAT;
                            r_nav_pulse[i] <= ~w_nav_other[i];
                            r_hcnt[i]      <= '0;
                        end else begin
                            r_hcnt[i] <= r_hcnt[i] + 1'b1;
                        end
`endif
                    end
`ifdef CTRL_AUTOREPEAT_EN
                    REPEAT: begin
                        if (!w_nav_d[i]) begin
                            r_state[i] <= IDLE;
                        end else if (r_hcnt[i] == REPEAT_TERM) begin
                            r_nav_pulse[i] <= ~w_nav_other[i];
                            r_hcnt[i]      <= '0;
                        end else begin
                            r_hcnt[i] <= r_hcnt[i] + 1'b1;
                        end
                    end
`endif
                    default: r_state[i] <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_rst_d_q   <= 1'b0;
            r_rst_pulse <= 1'b0;
            r_lvl       <= '0;
        end else begin
            r_rst_d_q   <= w_d[CH_RST];
            r_rst_pulse <= w_d[CH_RST] & ~r_rst_d_q;
            r_lvl       <= {w_d[CH_F2], w_d[CH_F1], w_d[CH_PAUSA]};
        end
    end

    assign anterior_pulse  = r_nav_pulse[0];
    assign siguiente_pulse = r_nav_pulse[1];
    assign rst_pulse       = r_rst_pulse;
    assign pausa_lvl       = r_lvl[0];
    assign filtro1_lvl     = r_lvl[1];
    assign filtro2_lvl     = r_lvl[2];

endmodule

// File: tb/tb_ctrl_input_conditioner.sv
// Directed bench for ctrl_input_conditioner with DEBOUNCE=4, HOLD=20, REPEAT=8.
// Honors CTRL_AUTOREPEAT_EN to select the expected previous/next pulse trains.
module tb_ctrl_input_conditioner;

`ifdef CTRL_AUTOREPEAT_EN
    localparam int AR = 1;
`else
    localparam int AR = 0;
`endif

    logic clk_clk = 1'b0;
    logic reset_reset_n;
    logic anterior_key_n, siguiente_key_n, rst_key_n;
    logic pausa_sw, filtro1_sw, filtro2_sw;
    logic anterior_pulse, siguiente_pulse, rst_pulse;
    logic pausa_lvl, filtro1_lvl, filtro2_lvl;

    int n_total = 0;
    int n_pass  = 0;

    ctrl_input_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (20),
        .REPEAT_CYCLES  (8)
    ) dut (
        .clk_clk        (clk_clk),
        .reset_reset_n  (reset_reset_n),
        .anterior_key_n (anterior_key_n),
        .siguiente_key_n(siguiente_key_n),
        .rst_key_n      (rst_key_n),
        .pausa_sw       (pausa_sw),
        .filtro1_sw     (filtro1_sw),
        .filtro2_sw     (filtro2_sw),
        .anterior_pulse (anterior_pulse),
        .siguiente_pulse(siguiente_pulse),
        .rst_pulse      (rst_pulse),
        .pausa_lvl      (pausa_lvl),
        .filtro1_lvl    (filtro1_lvl),
        .filtro2_lvl    (filtro2_lvl)
    );

    always #5 clk_clk = ~clk_clk;

    typedef struct {
        int ant_low;
        int sig_low;
        int run;
        int exp_ant_n;
        int exp_sig_n;
        bit excl;
    } nav_vec_t;

    nav_vec_t vecs [5];

    task automatic check(input string name, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    // Leaves the bench just after a posedge; the next posedge is edge 0.
    task automatic reset_dut();
        reset_reset_n   = 1'b0;
        anterior_key_n  = 1'b1;
        siguiente_key_n = 1'b1;
        rst_key_n       = 1'b1;
        pausa_sw        = 1'b0;
        filtro1_sw      = 1'b0;
        filtro2_sw      = 1'b0;
        repeat (3) tick();
        reset_reset_n = 1'b1;
        tick();
    endtask

    // Expected pulse at edge e for a lone key held low on edges 0..low-1.
    function automatic bit exp_pulse(input int e, input int low);
        if (low <= 0) return 1'b0;
        if (e == 6) return 1'b1;
        if (AR != 0 && e >= 26 && ((e - 26) % 8) == 0 && e <= low + 5) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [5:0] all_out();
        return {anterior_pulse, siguiente_pulse, rst_pulse, pausa_lvl, filtro1_lvl, filtro2_lvl};
    endfunction

    initial begin
        int a_n, s_n, a_bad, s_bad, first, f1_max;
        bit ea, es;

        vecs[0] = '{ant_low: 0,  sig_low: 10, run: 40, exp_ant_n: 0, exp_sig_n: 1, excl: 1'b0};
        vecs[1] = '{ant_low: 0,  sig_low: 60, run: 90, exp_ant_n: 0, exp_sig_n: (AR != 0) ? 6 : 1, excl: 1'b0};
        vecs[2] = '{ant_low: 60, sig_low: 0,  run: 90, exp_ant_n: (AR != 0) ? 6 : 1, exp_sig_n: 0, excl: 1'b0};
        vecs[3] = '{ant_low: 40, sig_low: 40, run: 70, exp_ant_n: 0, exp_sig_n: 0, excl: 1'b1};
        vecs[4] = '{ant_low: 10, sig_low: 0,  run: 30, exp_ant_n: 1, exp_sig_n: 0, excl: 1'b0};

        // Reset state, with inputs already driven active during reset.
        reset_reset_n   = 1'b0;
        anterior_key_n  = 1'b0;
        siguiente_key_n = 1'b0;
        rst_key_n       = 1'b0;
        pausa_sw        = 1'b1;
        filtro1_sw      = 1'b1;
        filtro2_sw      = 1'b1;
        repeat (8) tick();
        check("reset_outputs", int'(all_out()), 0);

        // Pause switch clean rise and a short glitch on filter 1.
        reset_dut();
        pausa_sw   = 1'b1;
        filtro1_sw = 1'b1;
        f1_max     = 0;
        for (int e = 0; e < 16; e++) begin
            tick();
            if (e == 5) check("pausa_lvl_edge5", int'(pausa_lvl), 0);
            if (e == 6) check("pausa_lvl_edge6", int'(pausa_lvl), 1);
            if (filtro1_lvl) f1_max = 1;
            if (e == 2) filtro1_sw = 1'b0;
        end
        check("filtro1_glitch_rejected", f1_max, 0);

        // Table-driven previous/next sequences.
        foreach (vecs[v]) begin
            reset_dut();
            anterior_key_n  = (vecs[v].ant_low > 0) ? 1'b0 : 1'b1;
            siguiente_key_n = (vecs[v].sig_low > 0) ? 1'b0 : 1'b1;
            a_n = 0; s_n = 0; a_bad = 0; s_bad = 0;
            for (int e = 0; e < vecs[v].run; e++) begin
                tick();
                ea = vecs[v].excl ? 1'b0 : exp_pulse(e, vecs[v].ant_low);
                es = vecs[v].excl ? 1'b0 : exp_pulse(e, vecs[v].sig_low);
                if (anterior_pulse)  a_n++;
                if (siguiente_pulse) s_n++;
                if (anterior_pulse  !== ea) a_bad++;
                if (siguiente_pulse !== es) s_bad++;
                if (e == vecs[v].ant_low - 1) anterior_key_n  = 1'b1;
                if (e == vecs[v].sig_low - 1) siguiente_key_n = 1'b1;
            end
            check($sformatf("vec%0d_ant_count", v), a_n, vecs[v].exp_ant_n);
            check($sformatf("vec%0d_sig_count", v), s_n, vecs[v].exp_sig_n);
            check($sformatf("vec%0d_ant_timing_errs", v), a_bad, 0);
            check($sformatf("vec%0d_sig_timing_errs", v), s_bad, 0);
        end

        // Reset asserted in the middle of a held previous press.
        reset_dut();
        anterior_key_n = 1'b0;
        pausa_sw       = 1'b1;
        a_n = 0;
        for (int e = 0; e < 16; e++) begin
            tick();
            if (anterior_pulse) a_n++;
        end
        check("midhold_first_press", a_n, 1);
        check("midhold_pausa_before_reset", int'(pausa_lvl), 1);
        reset_reset_n = 1'b0;
        #1;
        check("midhold_async_clear", int'(all_out()), 0);
        tick();
        tick();
        reset_reset_n = 1'b1;
        a_n = 0; first = -1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (anterior_pulse) begin
                a_n++;
                if (first < 0) first = k;
            end
        end
        check("midhold_repulse_count", a_n, (AR != 0) ? 1 : 1);
        check("midhold_repulse_edge", first, 6);

        // Reset button with 1-cycle bounces, then a solid 30-cycle press.
        reset_dut();
        rst_key_n = 1'b0;
        a_n = 0; first = -1;
        for (int e = 0; e < 50; e++) begin
            tick();
            if (rst_pulse) begin
                a_n++;
                if (first < 0) first = e;
            end
            if (e + 1 < 6)       rst_key_n = logic'((e + 1) % 2);
            else if (e + 1 < 36) rst_key_n = 1'b0;
            else                 rst_key_n = 1'b1;
        end
        check("rst_bounce_count", a_n, 1);
        check("rst_bounce_edge", first, 12);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
